// File: rtl/msu_sd_pkg.sv
// Shared constants, FSM state type and the byte-offset compare used by the
// MSU sector responder.
package msu_sd_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_WORDS = 256;
    localparam int OFF_W        = 41;

    typedef enum logic [2:0] {
        IDLE,
        ACK_WAIT,
        FETCH,
        WRITE,
        GAP,
        DONE
    } sd_state_e;

    // True when a byte offset lies at or beyond the end of the image.
    function automatic logic off_at_or_past(input logic [OFF_W-1:0] off,
                                            input logic [63:0]      size);
        return {23'd0, off} >= size;
    endfunction

endpackage

// File: rtl/msu_sd_zero_fill.sv
// Decides whether a word must be fetched and masks image bytes that fall
// past the end of the image.
module msu_sd_zero_fill
    import msu_sd_pkg::*;
(
    input  logic [OFF_W-1:0] off,
    input  logic [63:0]      size,
    input  logic [15:0]      mem_rdata,
    output logic [15:0]      data,
    output logic             need_fetch
);

    logic last_byte_only;

    assign need_fetch     = !off_at_or_past(off, size);
    // Only the low (even) byte of this word is still inside the image.
    assign last_byte_only = ({23'd0, off} + 64'd1) == size;

    assign data = !need_fetch    ? 16'h0000 :
                  last_byte_only ? {8'h00, mem_rdata[7:0]} :
                                   mem_rdata;

endmodule

// File: rtl/msu_sd_sector_responder.sv
// Host-side responder of the MSU sector-read handshake: acknowledges a
// request and streams one sector of words out of a backing memory.
module msu_sd_sector_responder
    import msu_sd_pkg::*;
#(
    parameter int SECTOR_WORDS = msu_sd_pkg::SECTOR_WORDS,
    parameter int ACK_LATENCY  = 4,
    parameter int WR_GAP       = 0,
    parameter int MEM_AW       = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       img_size,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    output logic              sd_ack,
    output logic [7:0]        sd_buff_addr,
    output logic [15:0]       sd_buff_dout,
    output logic              sd_buff_wr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic              busy,
    output logic              oob
);

    localparam int               IDX_W    = $clog2(SECTOR_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SECTOR_WORDS - 1);
    localparam int               BYTE_SH  = $clog2(SECTOR_BYTES);

    sd_state_e        state, state_n;
    logic [15:0]      cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [31:0]      lba, lba_n;
    logic [63:0]      size, size_n;
    logic [15:0]      data, data_n;
    logic             pending, pending_n;

    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] req_off;
    logic [15:0]      zf_data;
    logic             need_fetch;

    assign off     = (OFF_W'(lba) << BYTE_SH) + (OFF_W'(idx) << 1);
    assign req_off = OFF_W'(sd_lba) << BYTE_SH;

    msu_sd_zero_fill u_zero_fill (
        .off        (off),
        .size       (size),
        .mem_rdata  (mem_rdata),
        .data       (zf_data),
        .need_fetch (need_fetch)
    );

    // NOTE: the sequential process only uses non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            lba     <= '0;
            size    <= '0;
            data    <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            lba     <= lba_n;
            size    <= size_n;
            data    <= data_n;
            pending <= pending_n;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        lba_n     = lba;
        size_n    = size;
        data_n    = data;
        pending_n = pending;
        mem_rd    = 1'b0;

        case (state)
            IDLE: begin
                if (sd_rd) begin
                    lba_n   = sd_lba;
                    size_n  = img_size;
                    cnt_n   = 16'(ACK_LATENCY - 1);
                    state_n = ACK_WAIT;
                end
            end
            ACK_WAIT: begin
                if (cnt == '0) begin
                    idx_n   = '0;
                    state_n = FETCH;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            FETCH: begin
                // A response only counts while a read is outstanding here.
                if (!pending) begin
                    if (need_fetch) begin
                        mem_rd    = 1'b1;
                        pending_n = 1'b1;
                    end else begin
                        data_n  = zf_data;
                        state_n = WRITE;
                    end
                end else if (mem_valid) begin
                    data_n    = zf_data;
                    pending_n = 1'b0;
                    state_n   = WRITE;
                end
            end
            WRITE: begin
                if (idx == IDX_LAST) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx + 1'b1;
                    if (WR_GAP > 0) begin
                        cnt_n   = 16'(WR_GAP - 1);
                        state_n = GAP;
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = FETCH;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy         = state != IDLE;
    assign sd_ack       = (state == FETCH) || (state == WRITE) || (state == GAP);
    assign sd_buff_wr   = state == WRITE;
    assign sd_buff_addr = 8'(idx);
    assign sd_buff_dout = data;
    assign mem_addr     = MEM_AW'(lba) * MEM_AW'(SECTOR_WORDS) + MEM_AW'(idx);
    assign oob          = !reset && (state == IDLE) && sd_rd
                          && off_at_or_past(req_off, img_size);

endmodule

// File: doc/msu_sd_sector_responder.md
Name: msu_sd_sector_responder

Overview:
- Responder (host side) of the sector-read handshake used by the MSU audio fetcher. It answers `sd_rd`/`sd_lba` with `sd_ack` and streams one 512-byte sector as `SECTOR_WORDS` 16-bit writes (`sd_buff_wr`/addr/dout).
- Words come from a word-addressed backing memory holding the mounted image.
- Words beyond `img_size` are zero-filled and never fetched.
- Used as the HPS stand-in for simulation and for a BRAM/SDRAM-backed image on-chip.

Parameters:
- `SECTOR_WORDS`, 256, words per sector; power of two.
- `ACK_LATENCY`, 4, cycles from accepted request to `sd_ack` rising; must be ≥ 1.
- `WR_GAP`, 0, idle cycles inserted after each `sd_buff_wr` pulse.
- `MEM_AW`, 24, backing-memory word address width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `img_size` in 64: image size in bytes; sampled at request accept.
- `sd_lba` in 32: sector number; sampled at request accept.
- `sd_rd` in 1: read request, level.
- `sd_ack` out 1: transfer in progress.
- `sd_buff_addr` out 8: word index within sector.
- `sd_buff_dout` out 16: word data; low byte = even byte address.
- `sd_buff_wr` out 1: one-cycle write strobe.
- `mem_addr` out MEM_AW: word address, equal to `sd_lba*SECTOR_WORDS + idx` truncated to MEM_AW.
- `mem_rd` out 1: one-cycle read strobe.
- `mem_rdata` in 16: read data.
- `mem_valid` in 1: `mem_rdata` valid; one response per `mem_rd`, any latency ≥ 1.
- `busy` out 1: not IDLE.
- `oob` out 1: one-cycle pulse at accept if the sector starts at or beyond `img_size`.

Behaviour:
- **Reset** (any state): all outputs 0, state IDLE, word index 0, latched `lba`/`size` cleared. A `mem_valid` arriving outside FETCH is ignored.
- **IDLE:**
  - If `sd_rd`=1, latch `sd_lba` and `img_size` and go to ACK_WAIT with counter = `ACK_LATENCY`-1.
  - `oob` pulses this same cycle when `lba*512 ≥ img_size`.
  - `busy`=1 from the next cycle.
- **ACK_WAIT:** decrement the counter. At 0, `sd_ack`<=1, idx=0, go to FETCH. `sd_ack` is first seen high exactly `ACK_LATENCY` cycles after the accept edge.
- **FETCH:** compute `off = lba*512 + 2*idx` at 41-bit width and compare against the zero-extended `img_size`.
  - `off ≥ size`: data=0, go directly to WRITE without a `mem_rd`.
  - Otherwise: pulse `mem_rd` once and wait for `mem_valid`. If `off+1 == size`, mask the high byte to 0. Capture the data, then go to WRITE.
- **WRITE:** `sd_buff_wr`=1 for exactly one cycle, with `sd_buff_addr`=idx and `sd_buff_dout`=data.
  - If idx == `SECTOR_WORDS`-1, go to DONE.
  - Otherwise idx++ and go to GAP (if `WR_GAP`>0, wait `WR_GAP` cycles) then to FETCH.
- **DONE:** `sd_ack`<=0, return to IDLE. `sd_ack` falls the cycle after the last `sd_buff_wr`.
- **`sd_rd` handling:**
  - `sd_rd` is ignored while `busy`; requests are never queued.
  - The requester must drop `sd_rd` on seeing `sd_ack`.
  - `sd_rd` still high in IDLE after DONE starts a new transfer with the current `sd_lba`.
- **Write-pulse spacing:** with back-to-back `mem_valid` latency 1 and `WR_GAP`=0, `sd_buff_wr` pulses are exactly 3 cycles apart (FETCH, wait, WRITE). In zero-fill regions they are 2 cycles apart.
- **Input stability:** `img_size` and `sd_lba` changes mid-transfer have no effect.
- **Wrap:** `mem_addr` wraps modulo 2^MEM_AW. The idx counter never exceeds `SECTOR_WORDS`-1.
- **Empty image:** `img_size`=0 gives `oob`=1 and a full sector of zeros.

Decomposition:
- **Package `msu_sd_pkg`:**
  - `SECTOR_BYTES`=512 and `SECTOR_WORDS`=256 constants.
  - A state enum {IDLE, ACK_WAIT, FETCH, WRITE, GAP, DONE}.
  - A function for the byte-offset/size compare.
- **Sub-module `msu_sd_zero_fill`** (combinational): takes `off`, `size`, `mem_rdata` and outputs masked data plus `need_fetch`. Everything else stays in one FSM.

Test Plan:
1. `img_size`=2048, `sd_lba`=1, memory word n = n: `sd_ack` rises 4 cycles after accept, then 256 pulses with addr 0..255 and dout 256..511, `oob`=0. `sd_ack` falls one cycle after addr 255.
2. `img_size`=1028, `sd_lba`=2: words 0–1 come from memory. Words 2–255 are 0 with exactly 2 `mem_rd` pulses total.
3. `img_size`=1027, `sd_lba`=2, word 1 of sector = 0xABCD: dout at addr 1 = 0x00CD.
4. `img_size`=1028, `sd_lba`=5: `oob` pulses once, 256 zero words, 0 `mem_rd`.
5. `reset` asserted at word 100, then `mem_valid` arrives afterwards: outputs 0 next cycle and the stale `mem_valid` is ignored. A fresh `sd_rd` with `sd_lba`=0 produces a complete transfer starting at addr 0.
6. `sd_rd` held high and `sd_lba` changed mid-transfer, `WR_GAP`=2: pulse spacing is 5 cycles and the first transfer's data uses the original lba. A second transfer starts the cycle after DONE using the new lba.
